// File: rtl/perf_snap_reader_if.sv
// Snapshot word stream: valid/ready handshake carrying
// one counter word per transfer, last word flagged.
interface perf_snap_reader_if #(
  parameter int CNT_W = 32
) ();
  logic             snap_val;
  logic             snap_rdy;
  logic [CNT_W-1:0] snap_data;
  logic             snap_last;

  modport master (
    output snap_val,
    output snap_data,
    output snap_last,
    input  snap_rdy
  );

  modport slave (
    input  snap_val,
    input  snap_data,
    input  snap_last,
    output snap_rdy
  );
endinterface

// File: rtl/perf_snap_reader.sv
// Window perf counters (all/busy/mac) with snapshot streaming.
// PERF_SNAP_SEQ_EN adds a sequence-number header word.
module perf_snap_reader #(
  parameter int CNT_W = 32,
  parameter int SEQ_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic win_start,
  input  logic win_end,
  input  logic inc_busy,
  input  logic inc_mac,
  input  logic ovf_clr,
  output logic busy,
  output logic ovf,
  perf_snap_reader_if.master snap
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SEND
  } state_t;

`ifdef PERF_SNAP_SEQ_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
  localparam logic [1:0] IDX_OFS  = 2'd0;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
  localparam logic [1:0] IDX_OFS  = 2'd1;
`endif

  state_t state;
  state_t state_d;

  logic [CNT_W-1:0] cnt_all;
  logic [CNT_W-1:0] cnt_busy;
  logic [CNT_W-1:0] cnt_mac;
  logic [CNT_W-1:0] hold_all;
  logic [CNT_W-1:0] hold_busy;
  logic [CNT_W-1:0] hold_mac;
  logic [1:0]       idx;
  logic             start_pend;
  logic             ovf_q;

  logic [CNT_W-1:0] nxt_all;
  logic [CNT_W-1:0] nxt_busy;
  logic [CNT_W-1:0] nxt_mac;
  logic [CNT_W-1:0] header;
  logic [CNT_W-1:0] snap_word;
  logic [1:0]       wsel;
  logic             in_send;
  logic             fire;
  logic             last_word;
  logic             clr;
  logic             latch;
  logic             restart;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef PERF_SNAP_SEQ_EN
  logic [SEQ_W-1:0] seq;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq <= '0;
    end else if (fire && last_word) begin
      seq <= seq + 1'b1;
    end
  end

  assign header = CNT_W'(seq);
`else
  assign header = '0;
`endif

  assign in_send   = (state == SEND);
  assign fire      = in_send && snap.snap_rdy;
  assign last_word = (idx == LAST_IDX);
  assign restart   = start_pend || win_start;

  // Post-increment values: the win_end cycle itself is counted.
  assign nxt_all  = sat_inc(cnt_all);
  assign nxt_busy = inc_busy ? sat_inc(cnt_busy) : cnt_busy;
  assign nxt_mac  = inc_mac  ? sat_inc(cnt_mac)  : cnt_mac;

  always_comb begin
    state_d = state;
    clr     = 1'b0;
    latch   = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_start) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (win_end) begin
          state_d = SEND;
          latch   = 1'b1;
        end
      end
      SEND: begin
        if (fire && last_word) begin
          state_d = restart ? RUN : IDLE;
          clr     = restart;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_all  <= '0;
      cnt_busy <= '0;
      cnt_mac  <= '0;
    end else if (clr) begin
      cnt_all  <= '0;
      cnt_busy <= '0;
      cnt_mac  <= '0;
    end else if (state == RUN) begin
      cnt_all  <= nxt_all;
      cnt_busy <= nxt_busy;
      cnt_mac  <= nxt_mac;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_all  <= '0;
      hold_busy <= '0;
      hold_mac  <= '0;
    end else if (latch) begin
      hold_all  <= nxt_all;
      hold_busy <= nxt_busy;
      hold_mac  <= nxt_mac;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (fire) begin
      idx <= last_word ? 2'd0 : idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_pend <= 1'b0;
    end else if (in_send && !(fire && last_word)) begin
      start_pend <= restart;
    end else begin
      start_pend <= 1'b0;
    end
  end

  // A second win_end during drain is dropped; set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (in_send && win_end) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign wsel = idx + IDX_OFS;

  always_comb begin
    snap_word = '0;
    unique case (wsel)
      2'd0: snap_word = header;
      2'd1: snap_word = hold_all;
      2'd2: snap_word = hold_busy;
      2'd3: snap_word = hold_mac;
      default: snap_word = '0;
    endcase
  end

  assign snap.snap_val  = in_send;
  assign snap.snap_last = in_send && last_word;
  assign snap.snap_data = in_send ? snap_word : '0;
  assign busy           = (state != IDLE);
  assign ovf            = ovf_q;

endmodule

// File: doc/perf_snap_reader.md
PERF_SNAP_READER -- requirements
Module: perf_snap_reader

Interface
REQ-001 Parameter CNT_W, default 32, width of every window counter and of snap_data.
REQ-002 Parameter SEQ_W, default 16, width of the snapshot sequence number.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 win_start  input  1  pulse; opens a measurement window (block start strobe).
REQ-006 win_end  input  1  pulse; closes the window (block finish strobe).
REQ-007 inc_busy  input  1  per-cycle event: PE block doing useful work (no stall).
REQ-008 inc_mac  input  1  per-cycle event: MAC doing valid multiply-accumulate work.
REQ-009 ovf_clr  input  1  clears the sticky overrun flag.
REQ-010 snap_val  output  1  snapshot word valid.
REQ-011 snap_rdy  input  1  consumer ready; a word transfers when snap_val and snap_rdy are both 1.
REQ-012 snap_data  output  CNT_W  snapshot word.
REQ-013 snap_last  output  1  marks the final word of a snapshot.
REQ-014 busy  output  1  high in RUN or SEND.
REQ-015 ovf  output  1  sticky: a win_end arrived while a snapshot was still draining.

Function
REQ-016 FSM states SHALL be IDLE, RUN, SEND.
REQ-017 IDLE: win_start -> RUN, and cnt_all, cnt_busy, cnt_mac cleared to 0 on that edge; win_end ignored, even when it coincides with win_start.
REQ-018 RUN, every cycle: cnt_all +1; cnt_busy +1 if inc_busy; cnt_mac +1 if inc_mac; the win_end cycle is counted; win_start ignored.
REQ-019 Counters SHALL saturate at all-ones and never wrap.
REQ-020 RUN with win_end: the post-increment counters are latched into holding registers, state -> SEND, snap_val = 1 on the next cycle (1-cycle latency).
REQ-021 SEND word order: cnt_all, cnt_busy, cnt_mac; snap_last = 1 only on cnt_mac.
REQ-022 While snap_val and not snap_rdy, snap_data and snap_last SHALL hold stable; snap_val SHALL not drop before the transfer.
REQ-023 Words SHALL transfer back-to-back at one per cycle while snap_rdy = 1.
REQ-024 SEND with win_start: start_pend is set; after the last transfer the state goes to RUN with counters cleared if start_pend is set, otherwise to IDLE; start_pend clears on exit.
REQ-025 SEND with win_end: ovf set and the event dropped; the snapshot in flight is unaffected.
REQ-026 ovf_clr clears ovf; when ovf_clr and the setting event coincide, the set wins.
REQ-027 snap_val SHALL be 0 outside SEND.

Reset
REQ-028 While rst = 1, on every clk edge: state = IDLE; all counters, holding registers, word index, seq, start_pend = 0; outputs snap_val, snap_last, busy, ovf = 0; snap_data = 0.
REQ-029 rst during SEND SHALL abort the snapshot with no further words.

Configuration
REQ-030 Macro PERF_SNAP_SEQ_EN defined: each snapshot is preceded by a header word carrying seq zero-extended to CNT_W, giving 4 words per snapshot; seq increments modulo 2^SEQ_W after each last-word transfer.
REQ-031 PERF_SNAP_SEQ_EN undefined: no header and no seq register; 3 words per snapshot.

Verification
REQ-032 Window with win_start at cycle 0, win_end at cycle 10, inc_busy high for 4 cycles, inc_mac for 2, snap_rdy = 1 -> words 10, 4, 2, last on the third, snap_val rising at cycle 11.
REQ-033 Same window with snap_rdy low for 5 cycles after snap_val rises -> word 10 held stable for those 5 cycles, then 10, 4, 2 delivered on consecutive cycles.
REQ-034 win_end pulsed during SEND -> ovf = 1, snapshot intact, ovf stays 1 until an ovf_clr pulse.
REQ-035 win_start during SEND, then win_end 5 cycles after the last transfer -> second snapshot cnt_all = 5.
REQ-036 CNT_W = 4, window of 20 cycles with inc_busy always high -> cnt_all = 15, cnt_busy = 15.
REQ-037 PERF_SNAP_SEQ_EN defined, two windows -> headers 0 then 1; rst asserted mid-SEND -> snap_val = 0 the next cycle, seq = 0.
